pipeline_command_issuer: RTL and testbench
==========================================

# pipeline_command_issuer

Host-side initiator for the DSP pipeline's control port. It accepts a framed byte stream (from the SPI/UART front end) and decodes each frame into one pipeline command: instruction write, register write, register-commit, delay-buffer allocation or full reset. It drives the matching strobes and payload buses, then waits for the pipeline's acknowledgement or reset completion before accepting the next frame. It sits between the byte transport and `dsp_pipeline`.

## Interface
Parameters:
- `data_width`, 16: sample/control word width; must be a multiple of 8; DB = data_width/8.
- `n_blocks`, 256: block count; must be ≤ 256; BW = $clog2(n_blocks).
- `reg_addr_width`, 1: per-block register address bits (= `BLOCK_REG_ADDR_WIDTH`).
- `instr_width`, 32: instruction width (= `BLOCK_INSTR_WIDTH`); must be a multiple of 8; IB = instr_width/8.
- `timeout_cycles`, 1024: acknowledgement wait limit, in cycles.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_byte`  in  8  frame byte.
- `in_byte_valid`  in  1  byte present.
- `in_ready`  out  1  byte accepted when `in_ready & in_byte_valid`.
- `block_target`  out  BW  target block.
- `reg_target`  out  BW+reg_addr_width  {block, reg}.
- `instr_val`  out  instr_width  instruction word.
- `ctrl_data`  out  data_width  register value.
- `buf_init_delay`  out  2*data_width  delay length.
- `instr_write`, `reg_write`  out  1  level-held command requests.
- `instr_write_ack`, `reg_write_ack`  in  1  pipeline acknowledgements.
- `reg_writes_commit`, `alloc_delay`, `full_reset`  out  1  single-cycle pulses.
- `resetting`  in  1  pipeline reset in progress.
- `busy`  out  1  not in IDLE.
- `err_opcode`, `err_target`, `err_timeout`  out  1  sticky error flags.
- `cmds_done`  out  16  count of completed commands; wraps.

## Operation
- Frame format: opcode byte, then the payload, MSB-first.
  - 0x01 INSTR: block (1 byte), instruction (IB bytes).
  - 0x02 REG: block (1), reg (1; low reg_addr_width bits used), data (DB).
  - 0x03 COMMIT: no payload.
  - 0x04 ALLOC: delay (2·DB bytes).
  - 0x05 FULL_RESET: no payload.
- FSM states:
  - IDLE: `in_ready`=1. An accepted byte is latched as the opcode. Go to PAYLOAD if the payload length is > 0, else ISSUE. An unknown opcode sets `err_opcode`, the byte is dropped, and the FSM stays in IDLE.
  - PAYLOAD: `in_ready`=1. Bytes shift into the assembly registers and a byte counter decrements. On the last byte, go to ISSUE.
  - ISSUE: `in_ready`=0. If the block byte is ≥ n_blocks on INSTR/REG, set `err_target` and return to IDLE with no strobe. Otherwise:
    - INSTR/REG: assert `instr_write`/`reg_write` and go to WAIT_ACK.
    - COMMIT/ALLOC: pulse for 1 cycle, increment `cmds_done`, go to IDLE.
    - FULL_RESET: pulse `full_reset` and go to WAIT_RESET.
  - WAIT_ACK: hold the strobe and all payload buses. When the ack is sampled high, drop the strobe the same edge, increment `cmds_done`, and go to IDLE. If the timeout counter reaches timeout_cycles, drop the strobe, set `err_timeout`, and go to IDLE.
  - WAIT_RESET: wait for `resetting` to rise, then fall (timeout counter also applies). Then increment `cmds_done` and go to IDLE.
- Payload buses hold their last values between commands. Only the strobes signal validity.
- Error flags clear only on reset.

## Timing
- Reset (async assert): state IDLE; all strobes 0; all buses 0; `in_ready` 0 while reset is asserted and 1 from the first edge after release; flags 0; `cmds_done` 0.
- Latency:
  - Opcode accepted at edge t with payload length N: the last payload byte is accepted at ≥ t+N, and the strobe is high from the edge after it.
  - Zero-payload opcode: the pulse is high in cycle t+2.
- Byte gaps (`in_byte_valid`=0) stall PAYLOAD indefinitely; there is no frame timeout.
- Ack in the same cycle the strobe first rises is legal: strobe width is 1 cycle.
- The timeout counter starts at 0 on WAIT_ACK/WAIT_RESET entry.
- `reset` asserted mid-frame or mid-WAIT_ACK: the partial frame is discarded and the strobe drops immediately (async).

## Structure
- Shared package: opcode constants, payload-length function, state encoding.
- One sub-module, `byte_shift_assembler`: a width-parameterised MSB-first shift register plus down-counter, instanced once. It is sized to the largest payload (1+IB vs 2+DB vs 2·DB) and fields are sliced per opcode.

## Test plan
- REG frame 02 05 01 12 34 with ack after 3 cycles: `reg_write` high for exactly 3 cycles; `block_target`=5, `reg_target`=0x00B, `ctrl_data`=0x1234; `cmds_done`=1.
- INSTR frame 01 FF DE AD BE EF with immediate ack: `instr_val`=0xDEADBEEF, `block_target`=0xFF, 1-cycle `instr_write`.
- Frames 03 then 04 00 00 01 00: one-cycle `reg_writes_commit`, then one-cycle `alloc_delay` with `buf_init_delay`=0x100; `cmds_done`=2; back-to-back with no idle gap.
- Byte 0x7E, then REG with the ack never asserted: `err_opcode`=1; `err_timeout`=1 after 1024 cycles; `reg_write` low afterwards; next frame accepted.
- 05 with `resetting` high for 10 cycles: `full_reset` pulse; `busy` until `resetting` falls; `in_ready` held 0 throughout.
- `reset` low after 2 payload bytes of a REG frame: all outputs 0 asynchronously; a following complete frame decodes correctly.

Source files
------------

// File: rtl/pipeline_command_issuer_pkg.sv
// Shared opcodes, FSM encoding and frame-length helpers for the pipeline command issuer.
package pipeline_command_issuer_pkg;

  localparam logic [7:0] OP_INSTR  = 8'h01;
  localparam logic [7:0] OP_REG    = 8'h02;
  localparam logic [7:0] OP_COMMIT = 8'h03;
  localparam logic [7:0] OP_ALLOC  = 8'h04;
  localparam logic [7:0] OP_FRESET = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_RESET
  } state_e;

  function automatic logic [7:0] payload_len(input logic [7:0] op, input int db, input int ib);
    logic [7:0] len;
    len = 8'd0;
    case (op)
      OP_INSTR: len = 8'(1 + ib);
      OP_REG:   len = 8'(2 + db);
      OP_ALLOC: len = 8'(2 * db);
      default:  len = 8'd0;
    endcase
    return len;
  endfunction

  function automatic logic op_known(input logic [7:0] op);
    return (op >= OP_INSTR) && (op <= OP_FRESET);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pipeline_command_issuer_byte_shift_assembler.sv
// MSB-first byte shift register with a payload down-counter; o_last flags the final payload byte.
module byte_shift_assembler #(
  parameter int N_BYTES = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [7:0]           i_len,
  input  logic                 i_shift,
  input  logic [7:0]           i_byte,
  output logic [8*N_BYTES-1:0] o_data,
  output logic                 o_last
);

  logic [8*N_BYTES-1:0] r_data;
  logic [7:0]           r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      // clearing keeps short payloads zero-extended in the upper bytes
      r_data <= '0;
      r_cnt  <= i_len;
    end else if (i_shift) begin
      r_data <= {r_data[8*N_BYTES-9:0], i_byte};
      r_cnt  <= r_cnt - 8'd1;
    end
  end

  assign o_data = r_data;
  assign o_last = (r_cnt == 8'd1);

endmodule

// File: rtl/pipeline_command_issuer.sv
// Decodes framed host bytes into dsp_pipeline control commands and waits for ack / reset completion.
module pipeline_command_issuer
  import pipeline_command_issuer_pkg::*;
#(
  parameter int data_width     = 16,
  parameter int n_blocks       = 256,
  parameter int reg_addr_width = 1,
  parameter int instr_width    = 32,
  parameter int timeout_cycles = 1024,
  localparam int BW = $clog2(n_blocks)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_byte,
  input  logic                      in_byte_valid,
  output logic                      in_ready,
  output logic [BW-1:0]             block_target,
  output logic [BW+reg_addr_width-1:0] reg_target,
  output logic [instr_width-1:0]    instr_val,
  output logic [data_width-1:0]     ctrl_data,
  output logic [2*data_width-1:0]   buf_init_delay,
  output logic                      instr_write,
  output logic                      reg_write,
  input  logic                      instr_write_ack,
  input  logic                      reg_write_ack,
  output logic                      reg_writes_commit,
  output logic                      alloc_delay,
  output logic                      full_reset,
  input  logic                      resetting,
  output logic                      busy,
  output logic                      err_opcode,
  output logic                      err_target,
  output logic                      err_timeout,
  output logic [15:0]               cmds_done
);

  localparam int DB   = data_width / 8;
  localparam int IB   = instr_width / 8;
  localparam int MAXB = max3(1 + IB, 2 + DB, 2 * DB);
  localparam int TW   = $clog2(timeout_cycles + 1);

  state_e                  r_state, w_next;
  logic                    r_rdy_en;
  logic [7:0]              r_op;
  logic [TW-1:0]           r_tmo;
  logic                    r_seen_rst;
  logic [8*MAXB-1:0]       w_asm;
  logic                    w_last, w_accept, w_load, w_shift;
  logic                    w_ack, w_tmo, w_bad_blk, w_is_wr;
  logic [7:0]              w_len, w_blk_byte;

  logic [BW-1:0]               r_block;
  logic [BW+reg_addr_width-1:0] r_regt;
  logic [instr_width-1:0]      r_instr;
  logic [data_width-1:0]       r_data;
  logic [2*data_width-1:0]     r_delay;
  logic                        r_instr_wr, r_reg_wr, r_commit, r_alloc, r_freset;
  logic                        r_err_op, r_err_tgt, r_err_tmo;
  logic [15:0]                 r_cmds;

  // r_rdy_en holds in_ready low through reset and until the first edge after release
  assign in_ready   = r_rdy_en && ((r_state == ST_IDLE) || (r_state == ST_PAYLOAD));
  assign busy       = (r_state != ST_IDLE);
  assign w_accept   = in_ready && in_byte_valid;
  assign w_load     = (r_state == ST_IDLE) && w_accept;
  assign w_shift    = (r_state == ST_PAYLOAD) && w_accept;
  assign w_len      = payload_len(in_byte, DB, IB);
  assign w_is_wr    = (r_op == OP_INSTR) || (r_op == OP_REG);
  assign w_blk_byte = (r_op == OP_INSTR) ? w_asm[instr_width +: 8] : w_asm[data_width + 8 +: 8];
  assign w_bad_blk  = 32'(w_blk_byte) >= 32'(n_blocks);
  assign w_ack      = (r_op == OP_INSTR) ? instr_write_ack : reg_write_ack;
  assign w_tmo      = (r_tmo == TW'(timeout_cycles - 1));

  byte_shift_assembler #(.N_BYTES(MAXB)) u_asm (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_load),
    .i_len   (w_len),
    .i_shift (w_shift),
    .i_byte  (in_byte),
    .o_data  (w_asm),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (w_accept && op_known(in_byte)) w_next = (w_len == 8'd0) ? ST_ISSUE : ST_PAYLOAD;
      ST_PAYLOAD:
        if (w_accept && w_last) w_next = ST_ISSUE;
      ST_ISSUE:
        if (w_is_wr && w_bad_blk)      w_next = ST_IDLE;
        else if (w_is_wr)              w_next = ST_WAIT_ACK;
        else if (r_op == OP_FRESET)    w_next = ST_WAIT_RESET;
        else                           w_next = ST_IDLE;
      ST_WAIT_ACK:
        if (w_ack || w_tmo) w_next = ST_IDLE;
      ST_WAIT_RESET:
        if ((r_seen_rst && !resetting) || w_tmo) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_en   <= 1'b0;
      r_op       <= '0;
      r_tmo      <= '0;
      r_seen_rst <= 1'b0;
      r_block    <= '0;
      r_regt     <= '0;
      r_instr    <= '0;
      r_data     <= '0;
      r_delay    <= '0;
      r_instr_wr <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_commit   <= 1'b0;
      r_alloc    <= 1'b0;
      r_freset   <= 1'b0;
      r_err_op   <= 1'b0;
      r_err_tgt  <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_cmds     <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_commit <= 1'b0;
      r_alloc  <= 1'b0;
      r_freset <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (w_accept) begin
            if (op_known(in_byte)) r_op     <= in_byte;
            else                   r_err_op <= 1'b1;
          end
        ST_ISSUE: begin
          r_tmo      <= '0;
          r_seen_rst <= 1'b0;
          if (w_is_wr && w_bad_blk) begin
            r_err_tgt <= 1'b1;
          end else begin
            case (r_op)
              OP_INSTR: begin
                r_block    <= w_blk_byte[BW-1:0];
                r_instr    <= w_asm[instr_width-1:0];
                r_instr_wr <= 1'b1;
              end
              OP_REG: begin
                r_block  <= w_blk_byte[BW-1:0];
                r_regt   <= {w_blk_byte[BW-1:0], w_asm[data_width +: reg_addr_width]};
                r_data   <= w_asm[data_width-1:0];
                r_reg_wr <= 1'b1;
              end
              OP_COMMIT: begin
                r_commit <= 1'b1;
                r_cmds   <= r_cmds + 16'd1;
              end
              OP_ALLOC: begin
                r_delay <= w_asm[2*data_width-1:0];
                r_alloc <= 1'b1;
                r_cmds  <= r_cmds + 16'd1;
              end
              default: r_freset <= 1'b1;
            endcase
          end
        end
        ST_WAIT_ACK:
          if (w_ack) begin
            r_instr_wr <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_cmds     <= r_cmds + 16'd1;
          end else if (w_tmo) begin
            r_instr_wr <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_err_tmo  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        ST_WAIT_RESET: begin
          r_seen_rst <= r_seen_rst | resetting;
          if (r_seen_rst && !resetting) r_cmds    <= r_cmds + 16'd1;
          else if (w_tmo)               r_err_tmo <= 1'b1;
          else                          r_tmo     <= r_tmo + TW'(1);
        end
        default: ;
      endcase
    end
  end

  assign block_target      = r_block;
  assign reg_target        = r_regt;
  assign instr_val         = r_instr;
  assign ctrl_data         = r_data;
  assign buf_init_delay    = r_delay;
  assign instr_write       = r_instr_wr;
  assign reg_write         = r_reg_wr;
  assign reg_writes_commit = r_commit;
  assign alloc_delay       = r_alloc;
  assign full_reset        = r_freset;
  assign err_opcode        = r_err_op;
  assign err_target        = r_err_tgt;
  assign err_timeout       = r_err_tmo;
  assign cmds_done         = r_cmds;

endmodule

// File: tb/tb_pipeline_command_issuer.sv
// Scenario bench for pipeline_command_issuer: directed frames plus randomized frames against a field-level model.
module tb_pipeline_command_issuer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_byte_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  block_target;
  logic [8:0]  reg_target;
  logic [31:0] instr_val;
  logic [15:0] ctrl_data;
  logic [31:0] buf_init_delay;
  logic        instr_write, reg_write;
  logic        instr_write_ack = 1'b0, reg_write_ack = 1'b0;
  logic        reg_writes_commit, alloc_delay, full_reset;
  logic        resetting = 1'b0;
  logic        busy, err_opcode, err_target, err_timeout;
  logic [15:0] cmds_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_commit = 0, n_alloc = 0, n_freset = 0;
  int exp_cmds = 0;
  logic [7:0]  m_blk;
  logic [8:0]  m_regt;
  logic [31:0] m_instr;
  logic [15:0] m_data;
  logic [31:0] m_delay;

  pipeline_command_issuer dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_byte_valid(in_byte_valid), .in_ready(in_ready),
    .block_target(block_target), .reg_target(reg_target), .instr_val(instr_val), .ctrl_data(ctrl_data),
    .buf_init_delay(buf_init_delay), .instr_write(instr_write), .reg_write(reg_write),
    .instr_write_ack(instr_write_ack), .reg_write_ack(reg_write_ack),
    .reg_writes_commit(reg_writes_commit), .alloc_delay(alloc_delay), .full_reset(full_reset),
    .resetting(resetting), .busy(busy), .err_opcode(err_opcode), .err_target(err_target),
    .err_timeout(err_timeout), .cmds_done(cmds_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_writes_commit) n_commit++;
    if (alloc_delay)       n_alloc++;
    if (full_reset)        n_freset++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    in_byte = b;
    in_byte_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte: in_ready=%b, required 1 within 2000 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int maxgap);
    foreach (f[i]) send_byte(f[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  // Plays the pipeline: raises ack in the delay-th cycle of the strobe (0 = never); returns strobe width.
  task automatic run_ack(input bit is_instr, input int delay, output int width);
    logic s;
    width = 0;
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk);
      #1;
      s = is_instr ? instr_write : reg_write;
      if (s) begin
        width++;
        if (width == delay) begin
          if (is_instr) instr_write_ack = 1'b1;
          else          reg_write_ack = 1'b1;
        end
      end else if (width > 0 || c > 3) begin
        break;
      end
    end
    instr_write_ack = 1'b0;
    reg_write_ack   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, busy, instr_write, reg_write, reg_writes_commit, alloc_delay, full_reset,
         err_opcode, err_target, err_timeout} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready/busy/strobes/flags=%b, required 0", {in_ready, busy, instr_write,
               reg_write, reg_writes_commit, alloc_delay, full_reset, err_opcode, err_target, err_timeout});
    end
    n_checks++;
    if ({block_target, reg_target, instr_val, ctrl_data, buf_init_delay, cmds_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: buses/cmds_done not zero (cmds_done=%0d)", cmds_done);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ready: in_ready=%b before first edge, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after_edge: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_reg_frame();
    int w;
    send_frame('{8'h02, 8'h05, 8'h01, 8'h12, 8'h34}, 0);
    run_ack(1'b0, 3, w);
    exp_cmds++;
    n_checks++;
    if (w !== 3) begin n_fail++; $display("FAIL reg_width: reg_write width=%0d, required 3", w); end
    n_checks++;
    if ({block_target, reg_target, ctrl_data} !== {8'h05, 9'h00B, 16'h1234}) begin
      n_fail++;
      $display("FAIL reg_fields: blk=%h reg=%h data=%h, required 05 00b 1234", block_target, reg_target, ctrl_data);
    end
    n_checks++;
    if (cmds_done !== 16'(exp_cmds)) begin
      n_fail++; $display("FAIL reg_cmds: cmds_done=%0d, required %0d", cmds_done, exp_cmds);
    end
  endtask

  task automatic test_instr_frame();
    int w;
    send_frame('{8'h01, 8'hFF, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
    run_ack(1'b1, 1, w);
    exp_cmds++;
    n_checks++;
    if (w !== 1) begin n_fail++; $display("FAIL instr_width: instr_write width=%0d, required 1", w); end
    n_checks++;
    if ({instr_val, block_target} !== {32'hDEADBEEF, 8'hFF}) begin
      n_fail++; $display("FAIL instr_fields: instr=%h blk=%h, required deadbeef ff", instr_val, block_target);
    end
    n_checks++;
    if (cmds_done !== 16'(exp_cmds)) begin
      n_fail++; $display("FAIL instr_cmds: cmds_done=%0d, required %0d", cmds_done, exp_cmds);
    end
  endtask

  task automatic test_back_to_back();
    int c0, a0;
    c0 = n_commit;
    a0 = n_alloc;
    send_frame('{8'h03, 8'h04, 8'h00, 8'h00, 8'h01, 8'h00}, 0);
    repeat (3) @(posedge clk);
    #1;
    exp_cmds += 2;
    n_checks++;
    if ((n_commit - c0) !== 1 || (n_alloc - a0) !== 1) begin
      n_fail++;
      $display("FAIL b2b_pulses: commit cycles=%0d alloc cycles=%0d, required 1 and 1", n_commit - c0, n_alloc - a0);
    end
    n_checks++;
    if (buf_init_delay !== 32'h100) begin
      n_fail++; $display("FAIL b2b_delay: buf_init_delay=%h, required 00000100", buf_init_delay);
    end
    n_checks++;
    if (cmds_done !== 16'(exp_cmds)) begin
      n_fail++; $display("FAIL b2b_cmds: cmds_done=%0d, required %0d", cmds_done, exp_cmds);
    end
  endtask

  task automatic test_errors();
    int w, c0;
    send_byte(8'h7E, 0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({err_opcode, busy} !== 2'b10) begin
      n_fail++; $display("FAIL err_opcode: err_opcode=%b busy=%b, required 1 0", err_opcode, busy);
    end
    send_frame('{8'h02, 8'h03, 8'h00, 8'hAA, 8'h55}, 0);
    run_ack(1'b0, 0, w);
    n_checks++;
    if (w !== 1024) begin n_fail++; $display("FAIL tmo_width: reg_write width=%0d, required 1024", w); end
    n_checks++;
    if ({err_timeout, reg_write} !== 2'b10) begin
      n_fail++; $display("FAIL tmo_flag: err_timeout=%b reg_write=%b, required 1 0", err_timeout, reg_write);
    end
    n_checks++;
    if (cmds_done !== 16'(exp_cmds)) begin
      n_fail++; $display("FAIL tmo_cmds: cmds_done=%0d, required %0d", cmds_done, exp_cmds);
    end
    c0 = n_commit;
    send_byte(8'h03, 0);
    repeat (3) @(posedge clk);
    #1;
    exp_cmds++;
    n_checks++;
    if ((n_commit - c0) !== 1 || cmds_done !== 16'(exp_cmds)) begin
      n_fail++;
      $display("FAIL after_err_frame: commit cycles=%0d cmds_done=%0d, required 1 %0d", n_commit - c0, cmds_done, exp_cmds);
    end
  endtask

  task automatic test_full_reset();
    int f0, bad, n;
    f0 = n_freset;
    bad = 0;
    n = 0;
    send_byte(8'h05, 0);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!full_reset && n < 5);
    resetting = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!busy || in_ready) bad++;
    end
    resetting = 1'b0;
    @(posedge clk);
    #1;
    exp_cmds++;
    n_checks++;
    if ((n_freset - f0) !== 1 || bad !== 0) begin
      n_fail++;
      $display("FAIL freset_hold: pulse cycles=%0d busy/ready violations=%0d, required 1 0", n_freset - f0, bad);
    end
    n_checks++;
    if (busy !== 1'b0 || cmds_done !== 16'(exp_cmds)) begin
      n_fail++;
      $display("FAIL freset_done: busy=%b cmds_done=%0d, required 0 %0d", busy, cmds_done, exp_cmds);
    end
  endtask

  task automatic test_reset_midframe();
    int w;
    send_frame('{8'h02, 8'h07, 8'h01}, 0);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, busy, reg_write, err_opcode, err_timeout, cmds_done, ctrl_data, block_target} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: ready=%b busy=%b err=%b%b cmds=%0d data=%h, required all 0",
               in_ready, busy, err_opcode, err_timeout, cmds_done, ctrl_data);
    end
    @(negedge clk);
    reset = 1'b1;
    send_frame('{8'h01, 8'h22, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
    @(posedge clk);
    #1;
    n_checks++;
    if (instr_write !== 1'b1) begin
      n_fail++; $display("FAIL waitack_strobe: instr_write=%b, required 1", instr_write);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({instr_write, instr_val, cmds_done} !== '0) begin
      n_fail++;
      $display("FAIL waitack_reset: instr_write=%b instr=%h cmds=%0d, required 0", instr_write, instr_val, cmds_done);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_cmds = 0;
    send_frame('{8'h02, 8'h09, 8'h01, 8'hC3, 8'h5A}, 0);
    run_ack(1'b0, 2, w);
    exp_cmds++;
    n_checks++;
    if (w !== 2 || {reg_target, ctrl_data, cmds_done} !== {9'h013, 16'hC35A, 16'(exp_cmds)}) begin
      n_fail++;
      $display("FAIL post_reset_frame: width=%0d reg=%h data=%h cmds=%0d, required 2 013 c35a %0d",
               w, reg_target, ctrl_data, cmds_done, exp_cmds);
    end
    m_blk = 8'h09; m_regt = 9'h013; m_data = 16'hC35A; m_instr = '0; m_delay = '0;
  endtask

  task automatic test_random();
    bq_t f;
    int op, dly, w, p0;
    logic [7:0] blk, rb;
    logic [31:0] v;
    for (int k = 0; k < 24; k++) begin
      op  = int'($urandom_range(4, 1));
      blk = 8'($urandom);
      rb  = 8'($urandom);
      v   = $urandom;
      dly = int'($urandom_range(5, 1));
      f   = {};
      f.push_back(8'(op));
      case (op)
        1: begin
          f.push_back(blk);
          for (int i = 3; i >= 0; i--) f.push_back(8'(v >> (8 * i)));
          m_blk = blk; m_instr = v;
        end
        2: begin
          f.push_back(blk); f.push_back(rb);
          f.push_back(8'(v >> 8)); f.push_back(8'(v));
          m_blk = blk; m_regt = 9'(blk * 2 + rb % 2); m_data = 16'(v % 65536);
        end
        3: ;
        default: begin
          for (int i = 3; i >= 0; i--) f.push_back(8'(v >> (8 * i)));
          m_delay = v;
        end
      endcase
      p0 = n_commit + n_alloc;
      send_frame(f, 2);
      if (op <= 2) begin
        run_ack(op == 1, dly, w);
        n_checks++;
        if (w !== dly) begin
          n_fail++; $display("FAIL rnd_width[%0d]: op=%0d strobe width=%0d, required %0d", k, op, w, dly);
        end
      end else begin
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ((n_commit + n_alloc - p0) !== 1) begin
          n_fail++; $display("FAIL rnd_pulse[%0d]: op=%0d pulse cycles=%0d, required 1", k, op, n_commit + n_alloc - p0);
        end
      end
      exp_cmds++;
      n_checks++;
      if ({block_target, reg_target, instr_val, ctrl_data, buf_init_delay, cmds_done} !==
          {m_blk, m_regt, m_instr, m_data, m_delay, 16'(exp_cmds)}) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: blk=%h reg=%h instr=%h data=%h dly=%h cmds=%0d, required %h %h %h %h %h %0d",
                 k, block_target, reg_target, instr_val, ctrl_data, buf_init_delay, cmds_done,
                 m_blk, m_regt, m_instr, m_data, m_delay, exp_cmds);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reg_frame();
    test_instr_frame();
    test_back_to_back();
    test_errors();
    test_full_reset();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
